// File: rtl/alu_rs_if.sv
// alu_rs_if: dispatch, CDB, flush and issue signals of the ALU reservation station.
// The slave modport is the reservation station; the master modport is its environment.
interface alu_rs_if #(
    parameter int unsigned TAG_W = 4,
    parameter int unsigned XLEN  = 32,
    parameter int unsigned FUN_W = 4
);
    logic                       flush;

    logic                       disp_valid;
    logic                       disp_ready;
    logic [FUN_W-1:0]           disp_fun;
    logic [TAG_W-1:0]           disp_tag;
    logic [1:0]                 disp_op_rdy;
    logic [1:0][XLEN-1:0]       disp_op_val;
    logic [1:0][TAG_W-1:0]      disp_op_tag;

    logic                       cdb_valid;
    logic [TAG_W-1:0]           cdb_tag;
    logic [XLEN-1:0]            cdb_value;

    logic                       issue_valid;
    logic                       issue_ready;
    logic [1:0][XLEN-1:0]       issue_ops;
    logic [FUN_W-1:0]           issue_fun;
    logic [TAG_W-1:0]           issue_tag;

    modport master (
        output flush,
        output disp_valid, disp_fun, disp_tag, disp_op_rdy, disp_op_val, disp_op_tag,
        input  disp_ready,
        output cdb_valid, cdb_tag, cdb_value,
        input  issue_valid, issue_ops, issue_fun, issue_tag,
        output issue_ready
    );

    modport slave (
        input  flush,
        input  disp_valid, disp_fun, disp_tag, disp_op_rdy, disp_op_val, disp_op_tag,
        output disp_ready,
        input  cdb_valid, cdb_tag, cdb_value,
        output issue_valid, issue_ops, issue_fun, issue_tag,
        input  issue_ready
    );
endinterface

// File: rtl/alu_rs.sv
// alu_rs: age-ordered reservation station for the integer ALU.
// Entries are compacted toward slot 0 (oldest); the oldest entry with both
// operands ready is offered to the ALU and removed on acceptance.
// Optional macro ALU_RS_WAKEUP_BYPASS_EN: an operand matching the CDB this
// cycle counts as ready for select and its value is forwarded to issue_ops.
module alu_rs #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 4,
    parameter int unsigned XLEN  = 32,
    parameter int unsigned FUN_W = 4
) (
    input  logic      clock,
    input  logic      reset,
    alu_rs_if.slave   bus
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned IDX_W = $clog2(DEPTH);

    typedef struct packed {
        logic                  valid;
        logic [FUN_W-1:0]      fun;
        logic [TAG_W-1:0]      tag;
        logic [1:0]            rdy;
        logic [1:0][XLEN-1:0]  val;
        logic [1:0][TAG_W-1:0] optag;
    } entry_t;

    entry_t             r_ent [DEPTH];
    logic [CNT_W-1:0]   r_count;

    logic [1:0]         w_match   [DEPTH];
    logic [1:0]         w_rdy_eff [DEPTH];
    entry_t             w_woke    [DEPTH];
    entry_t             w_up      [DEPTH];
    entry_t             w_nxt     [DEPTH];
    entry_t             w_new;
    logic [DEPTH-1:0]   w_elig;
    logic [IDX_W-1:0]   w_sel;
    logic               w_any;
    logic               w_fire;
    logic               w_disp;
    logic [CNT_W-1:0]   w_slot;
    logic [CNT_W-1:0]   w_cnt_nxt;

    // CDB tag match per pending operand, woken copy of each entry, select eligibility
    always_comb begin
        w_elig = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            w_woke[i] = r_ent[i];
            for (int k = 0; k < 2; k++) begin
                w_match[i][k] = bus.cdb_valid && r_ent[i].valid && !r_ent[i].rdy[k] &&
                                (r_ent[i].optag[k] == bus.cdb_tag);
                if (w_match[i][k]) begin
                    w_woke[i].rdy[k] = 1'b1;
                    w_woke[i].val[k] = bus.cdb_value;
                end
            end
`ifdef ALU_RS_WAKEUP_BYPASS_EN
            w_rdy_eff[i] = r_ent[i].rdy | w_match[i];
`else
            w_rdy_eff[i] = r_ent[i].rdy;
`endif
            w_elig[i] = r_ent[i].valid && (&w_rdy_eff[i]);
        end
    end

    // Oldest eligible entry wins
    always_comb begin
        w_sel = '0;
        w_any = 1'b0;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_sel = IDX_W'(i);
                w_any = 1'b1;
            end
        end
    end

    // Issue bundle; zero whenever nothing is offered
    always_comb begin
        bus.issue_valid = w_any && !reset && !bus.flush;
        bus.issue_ops   = '0;
        bus.issue_fun   = '0;
        bus.issue_tag   = '0;
        if (bus.issue_valid) begin
            bus.issue_fun = r_ent[w_sel].fun;
            bus.issue_tag = r_ent[w_sel].tag;
            for (int k = 0; k < 2; k++) begin
`ifdef ALU_RS_WAKEUP_BYPASS_EN
                bus.issue_ops[k] = w_match[w_sel][k] ? bus.cdb_value : r_ent[w_sel].val[k];
`else
                bus.issue_ops[k] = r_ent[w_sel].val[k];
`endif
            end
        end
    end

    // Each slot's shift-down source is its younger neighbour (empty past the top)
    for (genvar j = 0; j < int'(DEPTH); j++) begin : g_up
        if (j + 1 < int'(DEPTH)) begin : g_mid
            assign w_up[j] = w_woke[j+1];
        end else begin : g_last
            assign w_up[j] = '0;
        end
    end

    // Next entry state: wakeup, removal with compaction, dispatch into the youngest free slot
    always_comb begin
        bus.disp_ready = (r_count != CNT_W'(DEPTH)) && !reset && !bus.flush;
        w_fire         = bus.issue_valid && bus.issue_ready;
        w_disp         = bus.disp_valid && bus.disp_ready;
        w_slot         = r_count - CNT_W'(w_fire);
        w_cnt_nxt      = r_count + CNT_W'(w_disp) - CNT_W'(w_fire);

        w_new       = '0;
        w_new.valid = 1'b1;
        w_new.fun   = bus.disp_fun;
        w_new.tag   = bus.disp_tag;
        for (int k = 0; k < 2; k++) begin
            w_new.optag[k] = bus.disp_op_tag[k];
            if (bus.disp_op_rdy[k]) begin
                w_new.rdy[k] = 1'b1;
                w_new.val[k] = bus.disp_op_val[k];
            end else if (bus.cdb_valid && (bus.disp_op_tag[k] == bus.cdb_tag)) begin
                w_new.rdy[k] = 1'b1;
                w_new.val[k] = bus.cdb_value;
            end
        end

        for (int j = 0; j < int'(DEPTH); j++) begin
            w_nxt[j] = (w_fire && (IDX_W'(j) >= w_sel)) ? w_up[j] : w_woke[j];
        end
        if (w_disp) begin
            w_nxt[w_slot[IDX_W-1:0]] = w_new;
        end

        if (bus.flush) begin
            for (int j = 0; j < int'(DEPTH); j++) begin
                w_nxt[j] = '0;
            end
            w_cnt_nxt = '0;
        end
    end

    // Entry and occupancy registers
    always_ff @(posedge clock) begin
        if (reset) begin
            r_count <= '0;
            for (int j = 0; j < int'(DEPTH); j++) begin
                r_ent[j] <= '0;
            end
        end else begin
            r_count <= w_cnt_nxt;
            r_ent   <= w_nxt;
        end
    end
endmodule

// File: tb/tb_alu_rs.sv
// tb_alu_rs: directed scenarios followed by random traffic, every cycle
// checked against a queue-based model of the reservation station.
module tb_alu_rs;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned TAG_W = 4;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned FUN_W = 4;

`ifdef ALU_RS_WAKEUP_BYPASS_EN
    localparam bit BYP = 1'b1;
    localparam int LAT = 0;
`else
    localparam bit BYP = 1'b0;
    localparam int LAT = 1;
`endif

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    alu_rs_if #(.TAG_W(TAG_W), .XLEN(XLEN), .FUN_W(FUN_W)) bus ();

    alu_rs #(.DEPTH(DEPTH), .TAG_W(TAG_W), .XLEN(XLEN), .FUN_W(FUN_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [FUN_W-1:0]      fun;
        logic [TAG_W-1:0]      tag;
        logic [1:0]            rdy;
        logic [1:0][XLEN-1:0]  val;
        logic [1:0][TAG_W-1:0] optag;
    } m_ent_t;

    m_ent_t           q[$];
    int               n_cmp = 0;
    int               n_err = 0;
    int               e_idx;
    logic             e_valid;
    logic             e_ready;
    logic [FUN_W-1:0] e_fun;
    logic [TAG_W-1:0] e_tag;
    logic [XLEN-1:0]  e_op0;
    logic [XLEN-1:0]  e_op1;
    int               lat;

    task automatic chk(input string name, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic idle();
        bus.flush       = 1'b0;
        bus.disp_valid  = 1'b0;
        bus.disp_fun    = '0;
        bus.disp_tag    = '0;
        bus.disp_op_rdy = '0;
        bus.disp_op_val = '0;
        bus.disp_op_tag = '0;
        bus.cdb_valid   = 1'b0;
        bus.cdb_tag     = '0;
        bus.cdb_value   = '0;
        bus.issue_ready = 1'b0;
    endtask

    task automatic set_disp(input logic [FUN_W-1:0] fun, input logic [TAG_W-1:0] tag,
                            input logic [1:0] rdy, input logic [XLEN-1:0] v0,
                            input logic [XLEN-1:0] v1, input logic [TAG_W-1:0] t0,
                            input logic [TAG_W-1:0] t1);
        bus.disp_valid     = 1'b1;
        bus.disp_fun       = fun;
        bus.disp_tag       = tag;
        bus.disp_op_rdy    = rdy;
        bus.disp_op_val[0] = v0;
        bus.disp_op_val[1] = v1;
        bus.disp_op_tag[0] = t0;
        bus.disp_op_tag[1] = t1;
    endtask

    // Model view of this cycle: oldest entry whose operands are (or become, with bypass) ready
    task automatic compute_expected();
        logic [1:0] r;
        m_ent_t     s;
        e_idx = -1;
        for (int i = 0; i < q.size(); i++) begin
            r = q[i].rdy;
            for (int k = 0; k < 2; k++)
                if (BYP && bus.cdb_valid && !q[i].rdy[k] && q[i].optag[k] == bus.cdb_tag) r[k] = 1'b1;
            if (r == 2'b11 && e_idx < 0) e_idx = i;
        end
        e_valid = !reset && !bus.flush && (e_idx >= 0);
        e_ready = !reset && !bus.flush && (q.size() != int'(DEPTH));
        e_fun = '0; e_tag = '0; e_op0 = '0; e_op1 = '0;
        if (e_valid) begin
            s     = q[e_idx];
            e_fun = s.fun;
            e_tag = s.tag;
            e_op0 = s.rdy[0] ? s.val[0] : bus.cdb_value;
            e_op1 = s.rdy[1] ? s.val[1] : bus.cdb_value;
        end
    endtask

    task automatic settle();
        #2;
        compute_expected();
        chk("issue_valid", XLEN'(bus.issue_valid), XLEN'(e_valid));
        chk("disp_ready",  XLEN'(bus.disp_ready),  XLEN'(e_ready));
        chk("issue_fun",   XLEN'(bus.issue_fun),   XLEN'(e_fun));
        chk("issue_tag",   XLEN'(bus.issue_tag),   XLEN'(e_tag));
        chk("issue_op0",   bus.issue_ops[0],       e_op0);
        chk("issue_op1",   bus.issue_ops[1],       e_op1);
    endtask

    // Apply this cycle's inputs to the model, then cross the clock edge
    task automatic advance();
        bit     fire;
        bit     disp;
        m_ent_t t;
        fire = e_valid && bus.issue_ready;
        disp = bus.disp_valid && e_ready;
        if (reset || bus.flush) begin
            q.delete();
        end else begin
            for (int i = 0; i < q.size(); i++) begin
                t = q[i];
                for (int k = 0; k < 2; k++)
                    if (bus.cdb_valid && !t.rdy[k] && t.optag[k] == bus.cdb_tag) begin
                        t.rdy[k] = 1'b1;
                        t.val[k] = bus.cdb_value;
                    end
                q[i] = t;
            end
            if (fire) q.delete(e_idx);
            if (disp) begin
                t       = '0;
                t.fun   = bus.disp_fun;
                t.tag   = bus.disp_tag;
                t.optag = bus.disp_op_tag;
                for (int k = 0; k < 2; k++) begin
                    if (bus.disp_op_rdy[k]) begin
                        t.rdy[k] = 1'b1;
                        t.val[k] = bus.disp_op_val[k];
                    end else if (bus.cdb_valid && bus.disp_op_tag[k] == bus.cdb_tag) begin
                        t.rdy[k] = 1'b1;
                        t.val[k] = bus.cdb_value;
                    end
                end
                q.push_back(t);
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic cyc();
        settle();
        advance();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        idle();
        @(posedge clock);
        #1;

        // Reset state
        settle();
        chk("rst_disp_ready", XLEN'(bus.disp_ready), '0);
        chk("rst_issue_valid", XLEN'(bus.issue_valid), '0);
        advance();
        reset = 1'b0;
        settle();
        chk("post_rst_ready", XLEN'(bus.disp_ready), XLEN'(1));
        advance();

        // ADD with both operands ready issues the next cycle
        set_disp(4'd0, 4'd3, 2'b11, 32'd5, 32'd7, '0, '0);
        cyc();
        idle();
        bus.issue_ready = 1'b1;
        settle();
        chk("add_valid", XLEN'(bus.issue_valid), XLEN'(1));
        chk("add_op0", bus.issue_ops[0], 32'd5);
        chk("add_op1", bus.issue_ops[1], 32'd7);
        chk("add_tag", XLEN'(bus.issue_tag), XLEN'(3));
        advance();
        idle();
        settle();
        chk("add_removed", XLEN'(bus.issue_valid), '0);
        advance();

        // SUB with op1 waiting on tag 9
        set_disp(4'd1, 4'd4, 2'b01, 32'd2, '0, '0, 4'd9);
        cyc();
        idle();
        bus.cdb_valid = 1'b1; bus.cdb_tag = 4'd9; bus.cdb_value = 32'h10; bus.issue_ready = 1'b1;
        lat = -1;
        for (int c = 0; c < 3 && lat < 0; c++) begin
            settle();
            if (bus.issue_valid) begin
                lat = c;
                chk("sub_op1", bus.issue_ops[1], 32'h10);
                chk("sub_tag", XLEN'(bus.issue_tag), XLEN'(4));
            end
            advance();
            idle();
            bus.issue_ready = 1'b1;
        end
        chk("sub_latency", XLEN'(lat), XLEN'(LAT));
        idle();

        // Fill with pending entries, wake only the second one
        for (int i = 0; i < 4; i++) begin
            set_disp(4'd2, TAG_W'(i + 1), 2'b10, '0, XLEN'(100 + i), TAG_W'(10 + i), '0);
            cyc();
        end
        idle();
        settle();
        chk("full_ready", XLEN'(bus.disp_ready), '0);
        advance();
        bus.cdb_valid = 1'b1; bus.cdb_tag = 4'd11; bus.cdb_value = 32'h55; bus.issue_ready = 1'b1;
        lat = -1;
        for (int c = 0; c < 3 && lat < 0; c++) begin
            settle();
            if (bus.issue_valid) begin
                lat = c;
                chk("wake2_tag", XLEN'(bus.issue_tag), XLEN'(2));
                chk("wake2_op0", bus.issue_ops[0], 32'h55);
                chk("wake2_op1", bus.issue_ops[1], 32'd101);
            end
            advance();
            idle();
            bus.issue_ready = 1'b1;
        end
        chk("wake2_latency", XLEN'(lat), XLEN'(LAT));
        idle();
        settle();
        chk("after_wake_ready", XLEN'(bus.disp_ready), XLEN'(1));
        advance();

        // Flush three entries with a concurrent dispatch
        bus.flush = 1'b1;
        set_disp(4'd3, 4'd7, 2'b11, 32'd1, 32'd2, '0, '0);
        cyc();
        idle();
        settle();
        chk("flush_valid", XLEN'(bus.issue_valid), '0);
        chk("flush_ready", XLEN'(bus.disp_ready), XLEN'(1));
        advance();

        // Four ready entries: stall holds the oldest, full stays not-ready even while issuing
        for (int i = 0; i < 4; i++) begin
            set_disp(4'd5, TAG_W'(5 + i), 2'b11, XLEN'(2 * i + 1), XLEN'(2 * i + 2), '0, '0);
            cyc();
        end
        idle();
        for (int c = 0; c < 3; c++) begin
            settle();
            chk("stall_tag", XLEN'(bus.issue_tag), XLEN'(5));
            advance();
        end
        bus.issue_ready = 1'b1;
        settle();
        chk("full_issue_ready", XLEN'(bus.disp_ready), '0);
        chk("accept_tag", XLEN'(bus.issue_tag), XLEN'(5));
        advance();
        bus.issue_ready = 1'b0;
        settle();
        chk("younger_tag", XLEN'(bus.issue_tag), XLEN'(6));
        advance();
        bus.issue_ready = 1'b1;
        for (int c = 0; c < 4; c++) cyc();
        idle();

        // Same-cycle CDB capture at dispatch
        set_disp(4'd3, 4'd12, 2'b10, '0, 32'h1, 4'd5, '0);
        bus.cdb_valid = 1'b1; bus.cdb_tag = 4'd5; bus.cdb_value = 32'hdeadbeef;
        cyc();
        idle();
        settle();
        chk("cap_valid", XLEN'(bus.issue_valid), XLEN'(1));
        chk("cap_op0", bus.issue_ops[0], 32'hdeadbeef);
        chk("cap_tag", XLEN'(bus.issue_tag), XLEN'(12));
        bus.issue_ready = 1'b1;
        advance();

        // Random traffic with a narrow tag space to provoke matches
        for (int c = 0; c < 400; c++) begin
            idle();
            bus.flush          = ($urandom_range(0, 99) < 3);
            bus.disp_valid     = 1'($urandom_range(0, 1));
            bus.disp_fun       = FUN_W'($urandom_range(0, 15));
            bus.disp_tag       = TAG_W'($urandom_range(0, 15));
            bus.disp_op_rdy    = 2'($urandom_range(0, 3));
            bus.disp_op_val[0] = $urandom;
            bus.disp_op_val[1] = $urandom;
            bus.disp_op_tag[0] = TAG_W'($urandom_range(0, 7));
            bus.disp_op_tag[1] = TAG_W'($urandom_range(0, 7));
            bus.cdb_valid      = 1'($urandom_range(0, 1));
            bus.cdb_tag        = TAG_W'($urandom_range(0, 7));
            bus.cdb_value      = $urandom;
            bus.issue_ready    = ($urandom_range(0, 9) < 7);
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/alu_rs.md
# alu_rs

Reservation station feeding the integer ALU in the execute stage. Accepts dispatched ALU micro-ops whose source operands may still be pending on in-flight producers, captures results broadcast on the common data bus (CDB) by tag, and issues the oldest entry with both operands available as a valid/ops/fun bundle to the ALU. Sits between dispatch/rename and the ALU; the ALU result returns to the CDB tagged with `issue_tag`.

## Interface
- `DEPTH`, 4: number of entries (2..8)
- `TAG_W`, 4: producer/destination tag width

- `clock`  in  1  sole clock, rising edge
- `reset`  in  1  synchronous, active-high
- `flush`  in  1  synchronous squash of all entries
- `disp_valid`  in  1  dispatch request
- `disp_ready`  out  1  entry available
- `disp_fun`  in  alu_fun_t  ALU operation
- `disp_tag`  in  TAG_W  destination tag
- `disp_op_rdy`  in  2  per-operand: value already valid
- `disp_op_val`  in  xlen_t[1:0]  operand values (used where rdy=1)
- `disp_op_tag`  in  TAG_W×2  producer tags (used where rdy=0)
- `cdb_valid`  in  1  result broadcast
- `cdb_tag`  in  TAG_W  broadcast tag
- `cdb_value`  in  xlen_t  broadcast value
- `issue_valid`  out  bool  bundle valid to ALU
- `issue_ready`  in  1  ALU accepts bundle
- `issue_ops`  out  xlen_t[1:0]  operands, [0] = rs1 side
- `issue_fun`  out  alu_fun_t  operation
- `issue_tag`  out  TAG_W  destination tag

## Operation
- Entries kept in age order, slot 0 oldest; per entry: valid, fun, tag, per-operand {rdy, val, tag}.
- Dispatch: accepted when `disp_valid && disp_ready`; writes the lowest free slot after this cycle's compaction. `disp_ready = (count != DEPTH) && !reset && !flush`.
- Dispatch capture: an operand with rdy=0 whose tag equals `cdb_tag` while `cdb_valid` in the dispatch cycle is stored ready with `cdb_value`.
- Wakeup: each valid entry, each pending operand, tag match with `cdb_valid` → rdy=1, val=`cdb_value` at the edge. Both operands may wake on one broadcast.
- Select: oldest valid entry with both operands ready drives `issue_*`; `issue_valid` = such an entry exists and no `flush`/`reset`.
- Issue: on `issue_valid && issue_ready` the selected entry is removed at the edge; younger entries shift down one slot, preserving order.
- With `issue_valid=0`, `issue_ops`, `issue_fun`, `issue_tag` are all zero.
- Simultaneous issue + dispatch: legal; count unchanged; new entry lands at youngest slot after shift.
- Simultaneous issue + wakeup of a younger entry: wakeup applied to the entry at its shifted position.
- `flush`: all entries invalid at the edge; dispatch in the flush cycle dropped; no issue that cycle.
- `reset`: same as flush; dominates all inputs.

## Timing
- Reset values: all entries invalid, count 0, `disp_ready` 0 while reset high then 1, `issue_valid` 0, `issue_ops`/`issue_fun`/`issue_tag` 0.
- Issue path combinational from entry state (plus CDB under the macro); ALU is combinational, so dispatch of ready operands at edge N → `issue_valid` in cycle N+1.
- Wakeup at edge N → entry eligible in cycle N+1 (without macro).
- Full: `disp_ready`=0 at count=DEPTH even if an issue fires that cycle (no dispatch-through-issue when full).
- Stall: `issue_ready`=0 holds the bundle stable; an older entry waking later displaces it next cycle (oldest-ready rule re-evaluated every cycle).

## Configuration
- `ALU_RS_WAKEUP_BYPASS_EN` defined: an entry whose last pending operand matches the CDB this cycle is eligible for select this cycle, with `cdb_value` forwarded onto `issue_ops`; wakeup-to-issue latency 0 cycles.
- Undefined: eligibility uses registered rdy bits only; latency 1 cycle; no CDB path to issue outputs.

## Test plan
- Reset, then dispatch ADD, ops 5 and 7 both rdy, tag 3 → next cycle `issue_valid`=1, ops {5,7}, tag 3; removed on `issue_ready`.
- Dispatch SUB with op1 pending tag 9, then `cdb_valid` tag 9 value 0x10 → issue one cycle later (same cycle with macro), `issue_ops[1]`=0x10.
- Fill 4 entries with pending operands → `disp_ready`=0; wake entry 2 only → it issues, entries 3/4 shift, `disp_ready`=1.
- Two ready entries, `issue_ready`=0 for 3 cycles → older one held stable; on accept, younger issues next cycle.
- Dispatch with op0 tag equal to same-cycle CDB tag 5 value 0xdeadbeef → stored ready, issues with `issue_ops[0]`=0xdeadbeef.
- 3 valid entries, assert `flush` with concurrent dispatch → next cycle count 0, `issue_valid`=0, `disp_ready`=1.
